note_stream_reader: RTL and testbench

- Avalon-MM read master that fetches a block of 32-bit words (note/sample table) from the on-chip RAM slave and delivers them in order on a valid/ready stream to the tone/audio generator.
- Software (Nios II via a CSR wrapper) supplies base address and word count, then pulses start.
- Supports pipelined reads with waitrequest and readdatavalid, and bounds outstanding reads so returned data never overflows the internal FIFO.

---
 rtl/note_stream_reader_if.sv | 24 ++
 rtl/note_stream_reader.sv | 186 ++++++++++++++++++
 tb/tb_note_stream_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/note_stream_reader_if.sv
// Avalon-MM read bus plus valid/ready output stream used by note_stream_reader.
interface note_stream_reader_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output avm_address, avm_read, avm_byteenable, out_data, out_valid,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, out_data, out_valid,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready
  );
endinterface

// File: rtl/note_stream_reader.sv
// Avalon-MM read master streaming a word block from RAM through a first-word
// fall-through FIFO, with credit-bounded pipelined reads and abort/flush.
module note_stream_reader #(
  parameter int ADDR_W      = 14,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  note_stream_reader_if.master bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int SUM_W  = FCNT_W + PEND_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  logic              read_q, read_d, discard_q, discard_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept_s, stalled_s, abort_s, rdv_s, push_s, pop_s;
  logic              unused_s;

  assign unused_s = ^base_addr[1:0];

  // Handshake decode, outstanding-read credit and FIFO bookkeeping.
  always_comb begin
    accept_s  = read_q & ~bus.avm_waitrequest;
    stalled_s = read_q & bus.avm_waitrequest;
    abort_s   = abort & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
    rdv_s     = bus.avm_readdatavalid & (pend_q != PEND_W'(0));
    pop_s     = (fcnt_q != FCNT_W'(0)) & bus.out_ready;
    // Data returning for reads outstanding at abort time is dropped.
    push_s    = rdv_s & ~discard_q & ~abort_s &
                ((fcnt_q != FCNT_W'(FIFO_DEPTH)) | pop_s);
    pend_d    = pend_q + PEND_W'(accept_s) - PEND_W'(rdv_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fcnt_d    = fcnt_q;
    if (abort_s) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      fcnt_d   = FCNT_W'(0);
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = bus.avm_readdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      fcnt_d = fcnt_q + FCNT_W'(push_s) - FCNT_W'(pop_s);
    end
  end

  // Transfer sequencing and lookahead of the registered read request.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    discard_d = discard_q;
    if (accept_s) begin
      addr_d = addr_q + ADDR_W'(4);
    end else begin
      addr_d = addr_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = {base_addr[ADDR_W-1:2], 2'b00};
          rem_d     = word_count;
          discard_d = 1'b0;
          state_d   = (word_count == CNT_W'(0)) ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort_s) begin
          rem_d     = CNT_W'(0);
          discard_d = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          if (accept_s && (rem_q != CNT_W'(0))) begin
            rem_d = rem_q - CNT_W'(1);
          end else begin
            rem_d = rem_q;
          end
          state_d = (rem_d == CNT_W'(0)) ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (abort_s) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if ((pend_q == PEND_W'(0)) && (fcnt_q == FCNT_W'(0)) && !read_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A stalled request is held regardless of abort; otherwise issue on credit.
    if (stalled_s) begin
      read_d = 1'b1;
    end else begin
      read_d = (state_d == S_ISSUE) && (rem_d != CNT_W'(0)) &&
               ((SUM_W'(pend_d) + SUM_W'(fcnt_d)) < SUM_W'(FIFO_DEPTH)) &&
               (pend_d < PEND_W'(MAX_PENDING));
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State, counters and FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= ADDR_W'(0);
      rem_q     <= CNT_W'(0);
      pend_q    <= PEND_W'(0);
      fcnt_q    <= FCNT_W'(0);
      wr_ptr_q  <= PTR_W'(0);
      rd_ptr_q  <= PTR_W'(0);
      read_q    <= 1'b0;
      discard_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
      fcnt_q    <= fcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      read_q    <= read_d;
      discard_q <= discard_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_byteenable = 4'b1111;
  assign bus.out_valid      = (fcnt_q != FCNT_W'(0));
  assign bus.out_data       = mem_q[rd_ptr_q];
  assign busy               = busy_q;
  assign done               = done_q;
endmodule

// File: tb/tb_note_stream_reader.sv
// Directed bench for note_stream_reader: RAM slave model, transfer-level
// reference model compared every cycle, plus hand-computed literal pins.
module tb_note_stream_reader;
  logic        clk, rst_n, start, abort, busy, done;
  logic [13:0] base_addr;
  logic [12:0] word_count;

  note_stream_reader_if #(.ADDR_W(14)) bif ();

  note_stream_reader #(.ADDR_W(14), .FIFO_DEPTH(8), .MAX_PENDING(4), .CNT_W(13)) dut (
    .clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .bus(bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [13:0] a; int due; } ret_t;
  ret_t        ret_q[$];
  logic [13:0] acc_addrs[$];
  int          acc_cyc[$];
  logic [31:0] got_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, issued, returned, ret_raw, popped, done_cnt, done_cyc, reads_seen;
  int mcnt, lat, stall_left;
  bit disc, stall_en, ready_r, prev_stall;
  logic [13:0] mbase, prev_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [13:0] a);
    return 32'hCAFE_0000 | {18'd0, a};
  endfunction

  function automatic logic [13:0] exp_addr(input int i);
    logic [13:0] b;
    b = {mbase[13:2], 2'b00};
    return b + 14'(i * 4);
  endfunction

  // One clock: check outputs at negedge, drive slave/sink, then update the model.
  task automatic cycle();
    logic acc, pop, rdv_now;
    @(negedge clk);
    chk("out_valid", 32'(bif.out_valid), 32'(returned > popped));
    if (bif.out_valid) chk("out_data", bif.out_data, ram_word(exp_addr(popped)));
    if (prev_stall) begin
      chk("hold_read", 32'(bif.avm_read), 32'd1);
      chk("hold_addr", 32'(bif.avm_address), 32'(prev_addr));
    end
    chk("credit", 32'(((issued - ret_raw) <= 4) && ((issued - ret_raw) + (returned - popped) <= 8)), 32'd1);
    if (bif.avm_read) reads_seen++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    if (stall_left > 0) begin
      bif.avm_waitrequest = 1'b1;
      stall_left--;
    end else if (stall_en && $urandom_range(0, 1) == 1) begin
      bif.avm_waitrequest = 1'b1;
      stall_left = $urandom_range(0, 2);
    end else begin
      bif.avm_waitrequest = 1'b0;
    end
    rdv_now = (ret_q.size() > 0) && (ret_q[0].due <= cyc);
    if (rdv_now) begin
      bif.avm_readdatavalid = 1'b1;
      bif.avm_readdata      = ram_word(ret_q[0].a);
      void'(ret_q.pop_front());
    end else begin
      bif.avm_readdatavalid = 1'b0;
      bif.avm_readdata      = 32'hDEAD_BEEF;
    end
    bif.out_ready = ready_r;
    acc = bif.avm_read & ~bif.avm_waitrequest;
    pop = bif.out_valid & bif.out_ready;
    if (pop) got_q.push_back(bif.out_data);
    if (acc) begin
      chk("addr", 32'(bif.avm_address), 32'(exp_addr(issued)));
      chk("issue_limit", 32'(issued < mcnt), 32'd1);
      acc_addrs.push_back(bif.avm_address);
      acc_cyc.push_back(cyc);
      ret_q.push_back('{a: bif.avm_address, due: cyc + lat});
      issued++;
    end
    prev_stall = bif.avm_read & bif.avm_waitrequest;
    prev_addr  = bif.avm_address;
    @(posedge clk);
    #1;
    if (pop) popped++;
    if (abort) disc = 1'b1;
    if (rdv_now) begin
      ret_raw++;
      if (!disc) returned++;
    end
    if (abort) popped = returned;
    cyc++;
  endtask

  task automatic run_xfer(input logic [13:0] b, input int n, input int lat_i, input bit stall_i,
                          input int ready_hold, input int cap_exp, input int abort_at);
    int  start_cyc, issued_at_abort;
    bit  aborted;
    mbase = b; mcnt = n; lat = lat_i; stall_en = stall_i;
    issued = 0; returned = 0; ret_raw = 0; popped = 0; done_cnt = 0; reads_seen = 0;
    disc = 1'b0; aborted = 1'b0; issued_at_abort = 0; done_cyc = -1;
    acc_addrs.delete(); acc_cyc.delete(); got_q.delete();
    ready_r = (ready_hold <= 0);
    base_addr = b; word_count = 13'(n); start = 1'b1;
    start_cyc = cyc;
    cycle();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      ready_r = (k >= ready_hold);
      if (cap_exp != 0 && k == ready_hold) chk("issue_cap", 32'(issued), 32'(cap_exp));
      if (abort_at >= 0 && !aborted && issued == abort_at) begin
        chk("pending_at_abort", 32'(issued - ret_raw), 32'd2);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        aborted = 1'b1;
        issued_at_abort = issued;
        chk("flush_valid", 32'(bif.out_valid), 32'd0);
      end else begin
        cycle();
      end
    end
    if (done_cnt == 0) chk("timeout_done", 32'd0, 32'd1);
    for (int k = 0; k < 3; k++) cycle();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    if (aborted) begin
      chk("no_read_after_abort", 32'(issued), 32'(issued_at_abort));
    end else begin
      chk("issued_all", 32'(issued), 32'(n));
      chk("delivered_all", 32'(popped), 32'(n));
    end
    if (n == 0) begin
      chk("zero_no_read", 32'(reads_seen), 32'd0);
      chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd2);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 14'd0; word_count = 13'd0;
    bif.avm_waitrequest = 1'b0; bif.avm_readdata = 32'd0; bif.avm_readdatavalid = 1'b0;
    bif.out_ready = 1'b0;
    mbase = 14'd0; mcnt = 0; lat = 1; stall_left = 0; stall_en = 1'b0; ready_r = 1'b1;
    prev_stall = 1'b0; prev_addr = 14'd0; disc = 1'b0;
    issued = 0; returned = 0; ret_raw = 0; popped = 0; done_cnt = 0; reads_seen = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(bif.avm_read), 32'd0);
    chk("rst_addr", 32'(bif.avm_address), 32'd0);
    chk("rst_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_data", bif.out_data, 32'd0);
    chk("byteenable", 32'(bif.avm_byteenable), 32'hF);
    rst_n = 1'b1;
    repeat (2) cycle();

    run_xfer(14'h0100, 3, 1, 1'b0, 0, 0, -1);
    chk("pin_addr0", 32'(acc_addrs[0]), 32'h0100);
    chk("pin_addr1", 32'(acc_addrs[1]), 32'h0104);
    chk("pin_addr2", 32'(acc_addrs[2]), 32'h0108);
    chk("pin_back_to_back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
    chk("pin_data0", got_q[0], 32'hCAFE_0100);
    chk("pin_data2", got_q[2], 32'hCAFE_0108);

    run_xfer(14'h0200, 0, 1, 1'b0, 0, 0, -1);

    run_xfer(14'h0200, 20, 1, 1'b0, 40, 8, -1);
    chk("pin_last20", got_q[19], 32'hCAFE_024C);

    run_xfer(14'h0400, 6, 1, 1'b1, 0, 0, -1);

    run_xfer(14'h3FFE, 2, 1, 1'b0, 0, 0, -1);
    chk("pin_wrap0", 32'(acc_addrs[0]), 32'h3FFC);
    chk("pin_wrap1", 32'(acc_addrs[1]), 32'h0000);
    chk("pin_wrap_data", got_q[1], 32'hCAFE_0000);

    run_xfer(14'h0800, 10, 2, 1'b0, 1000, 0, 5);

    run_xfer(14'h0010, 1, 1, 1'b0, 0, 0, -1);
    chk("pin_restart", got_q[0], 32'hCAFE_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
